// File: rtl/semaphore_access_arbiter_if.sv
// rtl/semaphore_access_arbiter_if.sv - core request/response, router bus and status bundle
//
// Groups every non-clock/reset signal of semaphore_access_arbiter.
//   master : the request side (cores) drives Req/Op/SemId/Data and observes the rest
//   slave  : the arbiter drives Ack/Granted, router bus and status outputs
interface semaphore_access_arbiter_if #(
  parameter int NumberOfSemaphores = 4,
  parameter int NumberOfCores      = 2,
  parameter int SemIdW  = (NumberOfSemaphores > 1) ? $clog2(NumberOfSemaphores) : 1,
  parameter int CoreIdW = (NumberOfCores > 1) ? $clog2(NumberOfCores) : 1
);
  logic [NumberOfCores-1:0]        SEMAPHOREARBITER_Req_fromCore;
  logic [NumberOfCores-1:0]        SEMAPHOREARBITER_Op_fromCore;
  logic [SemIdW*NumberOfCores-1:0] SEMAPHOREARBITER_SemId_fromCore;
  logic [4*NumberOfCores-1:0]      SEMAPHOREARBITER_Data_fromCore;
  logic [NumberOfCores-1:0]        SEMAPHOREARBITER_Ack_toCore;
  logic [NumberOfCores-1:0]        SEMAPHOREARBITER_Granted_toCore;
  logic [7:0]                      SEMAPHOREARBITER_Addr_toRouter;
  logic                            SEMAPHOREARBITER_EN_toRouter;
  logic                            SEMAPHOREARBITER_WR_toRouter;
  logic [3:0]                      SEMAPHOREARBITER_Data_toRouter;
  logic [NumberOfSemaphores-1:0]   SEMAPHOREARBITER_OwnerValid;
  logic                            SEMAPHOREARBITER_Busy;

  modport master (
    output SEMAPHOREARBITER_Req_fromCore, SEMAPHOREARBITER_Op_fromCore,
           SEMAPHOREARBITER_SemId_fromCore, SEMAPHOREARBITER_Data_fromCore,
    input  SEMAPHOREARBITER_Ack_toCore, SEMAPHOREARBITER_Granted_toCore,
           SEMAPHOREARBITER_Addr_toRouter, SEMAPHOREARBITER_EN_toRouter,
           SEMAPHOREARBITER_WR_toRouter, SEMAPHOREARBITER_Data_toRouter,
           SEMAPHOREARBITER_OwnerValid, SEMAPHOREARBITER_Busy
  );

  modport slave (
    input  SEMAPHOREARBITER_Req_fromCore, SEMAPHOREARBITER_Op_fromCore,
           SEMAPHOREARBITER_SemId_fromCore, SEMAPHOREARBITER_Data_fromCore,
    output SEMAPHOREARBITER_Ack_toCore, SEMAPHOREARBITER_Granted_toCore,
           SEMAPHOREARBITER_Addr_toRouter, SEMAPHOREARBITER_EN_toRouter,
           SEMAPHOREARBITER_WR_toRouter, SEMAPHOREARBITER_Data_toRouter,
           SEMAPHOREARBITER_OwnerValid, SEMAPHOREARBITER_Busy
  );
endinterface

// File: rtl/semaphore_access_arbiter.sv
// rtl/semaphore_access_arbiter.sv - round-robin semaphore lock/release arbiter with ownership table
//
// Ports:
//   SEMAPHOREARBITER_Clk     : clock, rising edge
//   SEMAPHOREARBITER_nReset  : asynchronous active-low reset
//   bus (slave modport)      : per-core Req/Op/SemId/Data in, Ack/Granted out,
//                              router Addr/EN/WR/Data out, OwnerValid and Busy status
// One transaction per three cycles: IDLE (select) -> EXEC (bus write) -> RESP (ack).
module semaphore_access_arbiter #(
  parameter int NumberOfSemaphores = 4,
  parameter int NumberOfCores      = 2,
  parameter int SemIdW  = (NumberOfSemaphores > 1) ? $clog2(NumberOfSemaphores) : 1,
  parameter int CoreIdW = (NumberOfCores > 1) ? $clog2(NumberOfCores) : 1
) (
  input logic                      SEMAPHOREARBITER_Clk,
  input logic                      SEMAPHOREARBITER_nReset,
  semaphore_access_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                        state_q, state_d;
  logic [CoreIdW-1:0]            rr_ptr_q;
  logic [CoreIdW-1:0]            core_q;
  logic                          op_q;
  logic [SemIdW-1:0]             sem_q;
  logic                          ok_q;
  logic [CoreIdW-1:0]            owner_q [NumberOfSemaphores];
  logic [NumberOfSemaphores-1:0] owner_valid_q;
  logic                          en_q;
  logic [7:0]                    addr_q;
  logic [3:0]                    dout_q;
  logic [NumberOfCores-1:0]      ack_q;
  logic [NumberOfCores-1:0]      granted_q;

  // Round-robin winner search starting at rr_ptr_q
  logic               any_req;
  logic [CoreIdW-1:0] win_core;
  logic [CoreIdW-1:0] rr_next;
  int                 cand;

  always_comb begin
    any_req  = 1'b0;
    win_core = '0;
    cand     = 0;
    for (int i = 0; i < NumberOfCores; i++) begin
      cand = int'(rr_ptr_q) + i;
      if (cand >= NumberOfCores) cand = cand - NumberOfCores;
      if (!any_req && bus.SEMAPHOREARBITER_Req_fromCore[CoreIdW'(cand)]) begin
        any_req  = 1'b1;
        win_core = CoreIdW'(cand);
      end
    end
    rr_next = (int'(win_core) == NumberOfCores - 1) ? '0 : win_core + 1'b1;
  end

  // Decision for the winner, taken against the table as it stands at selection
  logic              win_op;
  logic [SemIdW-1:0] win_sem;
  logic [3:0]        win_data;
  logic              sem_ok, held, mine, win_ok;
  logic [7:0]        win_addr;

  always_comb begin
    win_op   = bus.SEMAPHOREARBITER_Op_fromCore[win_core];
    win_sem  = bus.SEMAPHOREARBITER_SemId_fromCore[int'(win_core)*SemIdW +: SemIdW];
    win_data = bus.SEMAPHOREARBITER_Data_fromCore[int'(win_core)*4 +: 4];
    sem_ok   = int'(win_sem) < NumberOfSemaphores;
    // Out-of-range IDs never index the table
    held     = sem_ok && owner_valid_q[win_sem];
    mine     = held && (owner_q[win_sem] == win_core);
    win_ok   = sem_ok && (win_op ? (!held || mine) : mine);
    win_addr = 8'(int'(win_sem) * NumberOfCores + int'(win_core));
  end

  // State register
  always_ff @(posedge SEMAPHOREARBITER_Clk or negedge SEMAPHOREARBITER_nReset) begin
    if (!SEMAPHOREARBITER_nReset) state_q <= IDLE;
    else                          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: latch winner, drive bus in EXEC, update table at end of EXEC, ack in RESP
  always_ff @(posedge SEMAPHOREARBITER_Clk or negedge SEMAPHOREARBITER_nReset) begin
    if (!SEMAPHOREARBITER_nReset) begin
      rr_ptr_q      <= '0;
      core_q        <= '0;
      op_q          <= 1'b0;
      sem_q         <= '0;
      ok_q          <= 1'b0;
      owner_valid_q <= '0;
      en_q          <= 1'b0;
      addr_q        <= '0;
      dout_q        <= '0;
      ack_q         <= '0;
      granted_q     <= '0;
      for (int s = 0; s < NumberOfSemaphores; s++) owner_q[s] <= '0;
    end else begin
      en_q      <= 1'b0;
      addr_q    <= '0;
      dout_q    <= '0;
      ack_q     <= '0;
      granted_q <= '0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            core_q   <= win_core;
            op_q     <= win_op;
            sem_q    <= win_sem;
            ok_q     <= win_ok;
            rr_ptr_q <= rr_next;
            if (win_ok) begin
              en_q   <= 1'b1;
              addr_q <= win_addr;
              dout_q <= win_op ? win_data : 4'd0;
            end
          end
        end
        EXEC: begin
          if (ok_q) begin
            if (op_q) begin
              owner_q[sem_q]       <= core_q;
              owner_valid_q[sem_q] <= 1'b1;
            end else begin
              owner_valid_q[sem_q] <= 1'b0;
            end
          end
          ack_q[core_q]     <= 1'b1;
          granted_q[core_q] <= ok_q;
        end
        default: ;
      endcase
    end
  end

  // Outputs: all straight from registers
  always_comb begin
    bus.SEMAPHOREARBITER_Busy           = (state_q != IDLE);
    bus.SEMAPHOREARBITER_EN_toRouter    = en_q;
    bus.SEMAPHOREARBITER_WR_toRouter    = en_q;
    bus.SEMAPHOREARBITER_Addr_toRouter  = addr_q;
    bus.SEMAPHOREARBITER_Data_toRouter  = dout_q;
    bus.SEMAPHOREARBITER_Ack_toCore     = ack_q;
    bus.SEMAPHOREARBITER_Granted_toCore = granted_q;
    bus.SEMAPHOREARBITER_OwnerValid     = owner_valid_q;
  end

endmodule

// File: tb/tb_semaphore_access_arbiter.sv
// tb/tb_semaphore_access_arbiter.sv - self-checking bench for semaphore_access_arbiter
module tb_semaphore_access_arbiter;
  localparam int NS = 4;
  localparam int NC = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Main instance: 4 semaphores, 2 cores
  semaphore_access_arbiter_if #(.NumberOfSemaphores(NS), .NumberOfCores(NC)) sif ();
  logic [1:0] req = '0, op = '0;
  logic [3:0] sem = '0;
  logic [7:0] dat = '0;
  assign sif.SEMAPHOREARBITER_Req_fromCore   = req;
  assign sif.SEMAPHOREARBITER_Op_fromCore    = op;
  assign sif.SEMAPHOREARBITER_SemId_fromCore = sem;
  assign sif.SEMAPHOREARBITER_Data_fromCore  = dat;

  semaphore_access_arbiter #(.NumberOfSemaphores(NS), .NumberOfCores(NC)) dut (
    .SEMAPHOREARBITER_Clk(clk),
    .SEMAPHOREARBITER_nReset(rst_n),
    .bus(sif)
  );

  // Second instance: 3 semaphores so that an out-of-range ID is expressible
  semaphore_access_arbiter_if #(.NumberOfSemaphores(3), .NumberOfCores(NC)) sif3 ();
  logic [1:0] req3 = '0, op3 = '0;
  logic [3:0] sem3 = '0;
  logic [7:0] dat3 = '0;
  assign sif3.SEMAPHOREARBITER_Req_fromCore   = req3;
  assign sif3.SEMAPHOREARBITER_Op_fromCore    = op3;
  assign sif3.SEMAPHOREARBITER_SemId_fromCore = sem3;
  assign sif3.SEMAPHOREARBITER_Data_fromCore  = dat3;

  semaphore_access_arbiter #(.NumberOfSemaphores(3), .NumberOfCores(NC)) dut3 (
    .SEMAPHOREARBITER_Clk(clk),
    .SEMAPHOREARBITER_nReset(rst_n),
    .bus(sif3)
  );

  logic       en, wr, busy;
  logic [7:0] addr;
  logic [3:0] dout, ov;
  logic [1:0] ack, gnt;
  assign en   = sif.SEMAPHOREARBITER_EN_toRouter;
  assign wr   = sif.SEMAPHOREARBITER_WR_toRouter;
  assign busy = sif.SEMAPHOREARBITER_Busy;
  assign addr = sif.SEMAPHOREARBITER_Addr_toRouter;
  assign dout = sif.SEMAPHOREARBITER_Data_toRouter;
  assign ov   = sif.SEMAPHOREARBITER_OwnerValid;
  assign ack  = sif.SEMAPHOREARBITER_Ack_toCore;
  assign gnt  = sif.SEMAPHOREARBITER_Granted_toCore;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_core(input int k, input bit r, input bit o, input int s, input int d);
    req[k]         = r;
    op[k]          = o;
    sem[k*2 +: 2]  = 2'(s);
    dat[k*4 +: 4]  = 4'(d);
  endtask

  typedef struct {
    int core; bit op; int sem; int dat; bit drop;
    bit g; bit en; int addr; int dout; int ov;
  } vec_t;

  vec_t tbl [11];

  // One isolated transaction starting from IDLE at a negedge
  task automatic do_vec(input vec_t v);
    set_core(v.core, 1'b1, v.op, v.sem, v.dat);
    @(negedge clk);
    chk("busy_exec", 32'(busy), 32'd1);
    chk("en_exec",   32'(en),   32'(v.en));
    chk("wr_exec",   32'(wr),   32'(v.en));
    chk("addr_exec", 32'(addr), v.en ? 32'(v.addr) : 32'd0);
    chk("data_exec", 32'(dout), v.en ? 32'(v.dout) : 32'd0);
    if (v.drop) req[v.core] = 1'b0;
    @(negedge clk);
    chk("ack_resp",     32'(ack),  32'(1 << v.core));
    chk("granted_resp", 32'(gnt),  v.g ? 32'(1 << v.core) : 32'd0);
    chk("ov_resp",      32'(ov),   32'(v.ov));
    chk("en_resp",      32'(en),   32'd0);
    req[v.core] = 1'b0;
    @(negedge clk);
    chk("ack_idle",  32'(ack),  32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    if (v.drop) begin
      repeat (3) begin
        @(negedge clk);
        chk("no_repeat", 32'({busy, ack}), 32'd0);
      end
    end
  endtask

  // Transaction-level reference model for the random phase: a schedule of
  // expected events keyed by cycle number, plus an owner table (-1 = free).
  int own [NS];
  int rr, next_free, bus_cyc, ack_cyc, ack_core, ov_due;
  bit ack_g;
  int exp_addr, exp_dout;
  logic [3:0] ov_cur, ov_pend;

  task automatic model_sample(input int n);
    int c, s; bit o, ok;
    if (n >= next_free && req != 0) begin
      c = -1;
      for (int i = 0; i < NC; i++)
        if (c < 0 && req[(rr + i) % NC]) c = (rr + i) % NC;
      s = int'(sem[c*2 +: 2]);
      o = op[c];
      if (s >= NS)   ok = 1'b0;
      else if (o)    ok = (own[s] < 0) || (own[s] == c);
      else           ok = (own[s] == c);
      if (ok) own[s] = o ? c : -1;
      bus_cyc  = ok ? n : -1;
      exp_addr = s * NC + c;
      exp_dout = o ? int'(dat[c*4 +: 4]) : 0;
      ack_cyc  = n + 1;
      ack_core = c;
      ack_g    = ok;
      ov_due   = n + 1;
      for (int k = 0; k < NS; k++) ov_pend[k] = (own[k] >= 0);
      rr        = (c + 1) % NC;
      next_free = n + 3;
    end
  endtask

  task automatic check_cycle(input int n);
    bit b;
    b = (n == bus_cyc);
    if (n == ov_due) ov_cur = ov_pend;
    chk("rnd_en",   32'(en),   32'(b));
    chk("rnd_wr",   32'(wr),   32'(b));
    chk("rnd_addr", 32'(addr), b ? 32'(exp_addr) : 32'd0);
    chk("rnd_data", 32'(dout), b ? 32'(exp_dout) : 32'd0);
    chk("rnd_ack",  32'(ack),  (n == ack_cyc) ? 32'(1 << ack_core) : 32'd0);
    chk("rnd_gnt",  32'(gnt),  (n == ack_cyc && ack_g) ? 32'(1 << ack_core) : 32'd0);
    chk("rnd_ov",   32'(ov),   32'(ov_cur));
    chk("rnd_busy", 32'(busy), 32'(n >= next_free - 3 && n <= next_free - 2));
  endtask

  task automatic drive(input int n);
    for (int c = 0; c < NC; c++) begin
      if (n == ack_cyc && ack_core == c) req[c] = 1'b0;
      else if (!req[c] && $urandom_range(0, 3) == 0)
        set_core(c, 1'b1, $urandom_range(0, 2) != 0, $urandom_range(0, 3), $urandom_range(0, 15));
    end
  endtask

  initial begin
    //           core op sem dat drop g  en addr dout ov
    tbl[0]  = '{1, 1, 2, 'hA, 0, 1, 1, 5, 'hA, 'b0100};
    tbl[1]  = '{1, 0, 2, 'h0, 0, 1, 1, 5, 'h0, 'b0000};
    tbl[2]  = '{0, 1, 3, 'h5, 0, 1, 1, 6, 'h5, 'b1000};
    tbl[3]  = '{1, 1, 3, 'h7, 0, 0, 0, 0, 'h0, 'b1000};
    tbl[4]  = '{1, 0, 3, 'h0, 0, 0, 0, 0, 'h0, 'b1000};
    tbl[5]  = '{0, 1, 0, 'h2, 0, 1, 1, 0, 'h2, 'b1001};
    tbl[6]  = '{0, 1, 0, 'h3, 0, 1, 1, 0, 'h3, 'b1001};
    tbl[7]  = '{1, 0, 0, 'h0, 0, 0, 0, 0, 'h0, 'b1001};
    tbl[8]  = '{0, 0, 1, 'h0, 0, 0, 0, 0, 'h0, 'b1001};
    tbl[9]  = '{0, 0, 3, 'h0, 0, 1, 1, 6, 'h0, 'b0001};
    tbl[10] = '{1, 1, 1, 'hF, 1, 1, 1, 3, 'hF, 'b0011};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ov",   32'(ov),   32'd0);
    chk("rst_bus",  32'({en, wr, addr, dout}), 32'd0);
    chk("rst_ack",  32'({ack, gnt}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) do_vec(tbl[i]);

    // Out-of-range ID and last valid ID on the 3-semaphore instance
    req3[0] = 1'b1; op3[0] = 1'b1; sem3[1:0] = 2'd3; dat3[3:0] = 4'h6;
    @(negedge clk);
    chk("oor_en", 32'(sif3.SEMAPHOREARBITER_EN_toRouter), 32'd0);
    @(negedge clk);
    chk("oor_ack", 32'(sif3.SEMAPHOREARBITER_Ack_toCore), 32'd1);
    chk("oor_gnt", 32'(sif3.SEMAPHOREARBITER_Granted_toCore), 32'd0);
    chk("oor_ov",  32'(sif3.SEMAPHOREARBITER_OwnerValid), 32'd0);
    req3[0] = 1'b0;
    @(negedge clk);
    req3[1] = 1'b1; op3[1] = 1'b1; sem3[3:2] = 2'd2; dat3[7:4] = 4'h9;
    @(negedge clk);
    chk("s2_en",   32'(sif3.SEMAPHOREARBITER_EN_toRouter), 32'd1);
    chk("s2_addr", 32'(sif3.SEMAPHOREARBITER_Addr_toRouter), 32'd5);
    chk("s2_data", 32'(sif3.SEMAPHOREARBITER_Data_toRouter), 32'h9);
    @(negedge clk);
    chk("s2_gnt", 32'(sif3.SEMAPHOREARBITER_Granted_toCore), 32'd2);
    chk("s2_ov",  32'(sif3.SEMAPHOREARBITER_OwnerValid), 32'b100);
    req3[1] = 1'b0;
    @(negedge clk);

    // Reset asserted mid-EXEC of a successful core-0 lock
    set_core(0, 1'b1, 1'b1, 2, 4);
    @(negedge clk);
    chk("pre_rst_en", 32'(en), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_bus",  32'({en, wr}), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ov",   32'(ov), 32'd0);
    chk("mid_rst_ack",  32'(ack), 32'd0);
    @(negedge clk);

    // Fairness from reset: both cores request continuously
    set_core(0, 1'b1, 1'b1, 2, 1);
    set_core(1, 1'b1, 1'b1, 3, 2);
    rst_n = 1'b1;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      chk("fair_ack", 32'(ack), (j % 3 == 1) ? 32'(1 << ((j / 3) % 2)) : 32'd0);
      chk("fair_gnt", 32'(gnt), (j % 3 == 1) ? 32'(1 << ((j / 3) % 2)) : 32'd0);
      chk("fair_en",  32'(en),  32'(j % 3 == 0));
    end
    req = '0;
    repeat (3) @(negedge clk);

    // Randomized phase against the reference model
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < NS; k++) own[k] = -1;
    rr = 0; next_free = 0; bus_cyc = -1; ack_cyc = -1; ack_core = 0; ov_due = -1;
    ack_g = 1'b0; exp_addr = 0; exp_dout = 0; ov_cur = '0; ov_pend = '0;
    for (int n = 0; n < 1500; n++) begin
      @(posedge clk);
      model_sample(n);
      @(negedge clk);
      check_cycle(n);
      drive(n);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
